// File: rtl/if_sequencer.sv
// if_sequencer: fetch-side controller that owns the program counter.
// It selects the next PC with priority reset, then register branch, then
// PC-relative branch, then PC+4. It runs a req/ack handshake with a
// variable-latency instruction memory and hands each fetched word to
// decode with a valid/stall handshake.
// Optional build macro IF_SEQ_ALIGN_CHECK_EN: when defined, a redirect to a
// target that is not word aligned sets the sticky misalign flag and halts.
// When it is not defined, the low two target bits are cleared and the
// redirect proceeds.
module if_sequencer #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [63:0] br_target_i,
  input  logic        br_reg_i,
  input  logic [63:0] br_reg_target_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [63:0] if_pc_o,
  output logic [63:0] if_pc_plus4_o,
  output logic        fault_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DELIVER,
    S_DRAIN,
    S_HALT
  } state_e;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] tgt_q, tgt_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] ifPc_q, ifPc_d;
  logic [63:0] ifPcPlus4_q, ifPcPlus4_d;
  logic [7:0]  wait_q, wait_d;
  logic        fault_q, fault_d;
  logic        misalign_q, misalign_d;

  logic        redirect;
  logic [63:0] rawTarget;
  logic [63:0] redirTarget;
  logic        badAlign;
  logic [7:0]  waitInc;
  logic        timeout;

  // Resolve the redirect request: the register branch wins over the
  // PC-relative branch when both pulse together.
  always_comb begin
    redirect  = br_reg_i | br_taken_i;
    rawTarget = br_reg_i ? br_reg_target_i : br_target_i;
`ifdef IF_SEQ_ALIGN_CHECK_EN
    redirTarget = rawTarget;
    badAlign    = redirect && (rawTarget[1:0] != 2'b00);
`else
    redirTarget = rawTarget & ~64'h3;
    badAlign    = 1'b0;
`endif
    waitInc = wait_q + 8'd1;
    timeout = (waitInc == MAX_WAIT_C);
  end

  // Next-state, datapath updates and handshake outputs for the fetch FSM.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    instr_d     = instr_q;
    ifPc_d      = ifPc_q;
    ifPcPlus4_d = ifPcPlus4_q;
    wait_d      = wait_q;
    fault_d     = fault_q;
    misalign_d  = misalign_q;
    imem_req_o  = 1'b0;
    if_valid_o  = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (badAlign) begin
          misalign_d = 1'b1;
          state_d    = S_HALT;
        end else if (redirect) begin
          wait_d = 8'd0;
          if (imem_ack_i) begin
            pc_d    = redirTarget;
            state_d = S_FETCH;
          end else begin
            tgt_d   = redirTarget;
            state_d = S_DRAIN;
          end
        end else if (imem_ack_i) begin
          instr_d     = imem_rdata_i;
          ifPc_d      = pc_q;
          ifPcPlus4_d = pc_q + 64'd4;
          wait_d      = 8'd0;
          state_d     = S_DELIVER;
        end else begin
          wait_d = waitInc;
          if (timeout) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end
        end
      end
      S_DELIVER: begin
        if_valid_o = 1'b1;
        if (badAlign) begin
          misalign_d = 1'b1;
          state_d    = S_HALT;
        end else if (redirect) begin
          pc_d    = redirTarget;
          wait_d  = 8'd0;
          state_d = S_FETCH;
        end else if (!stall_i) begin
          pc_d    = pc_q + 64'd4;
          wait_d  = 8'd0;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        imem_req_o = 1'b1;
        if (badAlign) begin
          misalign_d = 1'b1;
          state_d    = S_HALT;
        end else if (imem_ack_i) begin
          pc_d    = redirect ? redirTarget : tgt_q;
          wait_d  = 8'd0;
          state_d = S_FETCH;
        end else begin
          if (redirect) begin
            tgt_d = redirTarget;
          end
          wait_d = waitInc;
          if (timeout) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State and datapath registers with synchronous reset to the reset vector.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      tgt_q       <= RESET_PC;
      instr_q     <= 32'd0;
      ifPc_q      <= 64'd0;
      ifPcPlus4_q <= 64'd0;
      wait_q      <= 8'd0;
      fault_q     <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      instr_q     <= instr_d;
      ifPc_q      <= ifPc_d;
      ifPcPlus4_q <= ifPcPlus4_d;
      wait_q      <= wait_d;
      fault_q     <= fault_d;
      misalign_q  <= misalign_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign if_instr_o    = instr_q;
  assign if_pc_o       = ifPc_q;
  assign if_pc_plus4_o = ifPcPlus4_q;
  assign fault_o       = fault_q;
  assign misalign_o    = misalign_q;

endmodule
